// File: rtl/tx_lane_scheduler_pkg.sv
// Shared definitions for the TX lane scheduler: FSM encoding, control
// characters and the skip ordered-set length.
package tx_lane_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_SKP_COM = 2'd2,
    ST_SKP     = 2'd3
  } sched_state_e;

  localparam logic [7:0] COM_CHAR = 8'hBC;
  localparam logic [7:0] SKP_CHAR = 8'h1C;
  localparam int unsigned SKP_SET_LEN = 3;

  // SKP_COM emits the first SKP byte, so the SKP state index stops one short.
  localparam logic [1:0] SKP_LAST_IDX = 2'(SKP_SET_LEN - 2);

endpackage

// File: rtl/tx_lane_scheduler_if.sv
// Requester / serializer bundle for tx_lane_scheduler, plus FSM state for observation.
interface tx_lane_scheduler_if;
  import tx_lane_scheduler_pkg::*;

  // Handshake: a requester byte is consumed on a rising clock edge exactly when
  // reqN_valid and reqN_ready are both 1; ready is combinational and is only
  // ever 1 in a byte_en slot. valid/data/last must hold until consumed.
  logic       byte_en;
  logic [7:0] req0_data;
  logic       req0_valid;
  logic       req0_last;
  logic       req0_ready;
  logic [7:0] req1_data;
  logic       req1_valid;
  logic       req1_last;
  logic       req1_ready;

  logic [7:0]   data_out;
  logic         k_out;
  logic         valid_out;
  logic [1:0]   grant;
  logic [15:0]  skip_count;
  sched_state_e state;

  modport master (
    output byte_en, req0_data, req0_valid, req0_last,
    output req1_data, req1_valid, req1_last,
    input  req0_ready, req1_ready,
    input  data_out, k_out, valid_out, grant, skip_count, state
  );

  modport slave (
    input  byte_en, req0_data, req0_valid, req0_last,
    input  req1_data, req1_valid, req1_last,
    output req0_ready, req1_ready,
    output data_out, k_out, valid_out, grant, skip_count, state
  );

endinterface

// File: rtl/tx_lane_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot combinational grant, and a 1-bit
// last-served pointer that moves only when a frame completes.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic [1:0] grant
);

  logic last_served_q;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_served_q ? 2'b01 : 2'b10;
    end
  end

  // Reset to requester 1 so requester 0 wins the first contested round.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_served_q <= 1'b1;
    end else if (advance) begin
      last_served_q <= served;
    end
  end

endmodule

// File: rtl/tx_lane_scheduler.sv
// Byte-slot scheduler for one TX lane: arbitrates two framed requesters and
// periodically inserts a COM + 3xSKP skip ordered set between frames.
module tx_lane_scheduler
  import tx_lane_scheduler_pkg::*;
#(
  parameter int unsigned SKIP_INTERVAL = 64
) (
  input logic              clock,
  input logic              reset,
  tx_lane_scheduler_if.slave bus
);

  localparam logic [15:0] SKIP_DUE_VAL = 16'(SKIP_INTERVAL - 1);

  sched_state_e state_q, state_d;
  logic [7:0]   data_q, data_d;
  logic         k_q, k_d;
  logic         vld_q, vld_d;
  logic [1:0]   grant_q, grant_d;
  logic [1:0]   skp_idx_q, skp_idx_d;
  logic [15:0]  skip_timer_q;
  logic         skip_due_q;
  logic [15:0]  skip_count_q;

  logic [1:0] req_valid;
  logic [1:0] arb_grant;
  logic [1:0] active_gnt;
  logic [1:0] ready;
  logic       sel;
  logic [7:0] sel_data;
  logic       sel_valid;
  logic       sel_last;
  logic       frame_done;
  logic       enter_skp;
  logic       skip_done;

  assign req_valid = {bus.req1_valid, bus.req0_valid};

  rr_arbiter2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req_valid),
    .advance (frame_done),
    .served  (sel),
    .grant   (arb_grant)
  );

  // A frame in progress keeps its owner; arbitration only matters in IDLE.
  assign active_gnt = (state_q == ST_SEND) ? grant_q : arb_grant;
  assign sel        = active_gnt[1];
  assign sel_data   = sel ? bus.req1_data  : bus.req0_data;
  assign sel_valid  = sel ? bus.req1_valid : bus.req0_valid;
  assign sel_last   = sel ? bus.req1_last  : bus.req0_last;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    k_d        = k_q;
    vld_d      = vld_q;
    grant_d    = grant_q;
    skp_idx_d  = skp_idx_q;
    ready      = 2'b00;
    frame_done = 1'b0;
    enter_skp  = 1'b0;
    skip_done  = 1'b0;
    if (bus.byte_en && !reset) begin
      case (state_q)
        ST_IDLE: begin
          if (skip_due_q) begin
            data_d    = COM_CHAR;
            k_d       = 1'b1;
            vld_d     = 1'b0;
            enter_skp = 1'b1;
            state_d   = ST_SKP_COM;
          end else if (|req_valid) begin
            ready  = arb_grant;
            data_d = sel_data;
            k_d    = 1'b0;
            vld_d  = 1'b1;
            if (sel_last) begin
              frame_done = 1'b1;
              grant_d    = 2'b00;
            end else begin
              grant_d = arb_grant;
              state_d = ST_SEND;
            end
          end else begin
            data_d = COM_CHAR;
            k_d    = 1'b1;
            vld_d  = 1'b0;
          end
        end
        ST_SEND: begin
          ready = grant_q;
          if (sel_valid) begin
            data_d = sel_data;
            k_d    = 1'b0;
            vld_d  = 1'b1;
            if (sel_last) begin
              frame_done = 1'b1;
              grant_d    = 2'b00;
              state_d    = ST_IDLE;
            end
          end else begin
            // Underrun: keep the link busy with COM fill, frame stays open.
            data_d = COM_CHAR;
            k_d    = 1'b1;
            vld_d  = 1'b0;
          end
        end
        ST_SKP_COM: begin
          data_d    = SKP_CHAR;
          k_d       = 1'b1;
          vld_d     = 1'b0;
          skp_idx_d = 2'd0;
          state_d   = ST_SKP;
        end
        ST_SKP: begin
          data_d = SKP_CHAR;
          k_d    = 1'b1;
          vld_d  = 1'b0;
          if (skp_idx_q == SKP_LAST_IDX) begin
            skip_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            skp_idx_d = skp_idx_q + 2'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      data_q    <= 8'h00;
      k_q       <= 1'b0;
      vld_q     <= 1'b0;
      grant_q   <= 2'b00;
      skp_idx_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      k_q       <= k_d;
      vld_q     <= vld_d;
      grant_q   <= grant_d;
      skp_idx_q <= skp_idx_d;
    end
  end

  // Skip timer freezes once a skip is owed and restarts when the set begins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skip_timer_q <= 16'd0;
      skip_due_q   <= 1'b0;
      skip_count_q <= 16'd0;
    end else if (bus.byte_en) begin
      if (enter_skp) begin
        skip_timer_q <= 16'd0;
        skip_due_q   <= 1'b0;
      end else if (!skip_due_q) begin
        skip_timer_q <= skip_timer_q + 16'd1;
        if (skip_timer_q + 16'd1 == SKIP_DUE_VAL) begin
          skip_due_q <= 1'b1;
        end
      end
      if (skip_done) begin
        skip_count_q <= skip_count_q + 16'd1;
      end
    end
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.data_out   = data_q;
  assign bus.k_out      = k_q;
  assign bus.valid_out  = vld_q;
  assign bus.grant      = grant_q;
  assign bus.skip_count = skip_count_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Directed bench for tx_lane_scheduler: stimulus tasks push the expected
// {data,k,valid,grant} per byte slot; a monitor pops and compares after each slot edge.
module tb_tx_lane_scheduler;
  import tx_lane_scheduler_pkg::*;

  localparam int W = 12;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  tx_lane_scheduler_if bus();

  tx_lane_scheduler #(.SKIP_INTERVAL(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  logic [W-1:0] mon_e;
  int           n_cmp = 0;
  int           n_bad = 0;
  string        cur_test = "init";

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s/%s: got %h, expected %h (t=%0t)", cur_test, name, act, req, $time);
    end
  endtask

  // Monitor: every byte_en edge outside reset produces one output byte.
  always @(posedge clock) begin
    if (bus.byte_en && !reset) begin
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s/slot_out: output slot with no expectation queued", cur_test);
      end else begin
        mon_e = exp_q.pop_front();
        check("slot_out", {4'h0, bus.data_out, bus.k_out, bus.valid_out, bus.grant},
              {4'h0, mon_e});
      end
    end
  end

  task automatic drive(input logic v0, input logic [7:0] d0, input logic l0,
                       input logic v1, input logic [7:0] d1, input logic l1);
    bus.req0_valid = v0; bus.req0_data = d0; bus.req0_last = l0;
    bus.req1_valid = v1; bus.req1_data = d1; bus.req1_last = l1;
  endtask

  task automatic slot(input logic v0, input logic [7:0] d0, input logic l0,
                      input logic v1, input logic [7:0] d1, input logic l1,
                      input logic [1:0] rdy, input logic [7:0] ed, input logic ek,
                      input logic ev, input logic [1:0] eg);
    @(negedge clock);
    drive(v0, d0, l0, v1, d1, l1);
    bus.byte_en = 1'b1;
    last_exp = {ed, ek, ev, eg};
    exp_q.push_back(last_exp);
    #1 check("ready", {14'h0, bus.req1_ready, bus.req0_ready}, {14'h0, rdy});
    @(posedge clock);
  endtask

  task automatic idle_slot(input logic [7:0] ed);
    slot(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00, ed, 1'b1, 1'b0, 2'b00);
  endtask

  // Non-byte_en cycles: readies stay low and outputs hold the last slot's value.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.byte_en = 1'b0;
      #1 check("gap_ready", {14'h0, bus.req1_ready, bus.req0_ready}, 16'h0000);
      @(posedge clock);
      #1 check("gap_hold", {4'h0, bus.data_out, bus.k_out, bus.valid_out, bus.grant},
               {4'h0, last_exp});
    end
  endtask

  task automatic quiet();
    @(negedge clock);
    bus.byte_en = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_reset_vals();
    check("rst_data", {8'h00, bus.data_out}, 16'h0000);
    check("rst_k_valid", {14'h0, bus.k_out, bus.valid_out}, 16'h0000);
    check("rst_grant", {14'h0, bus.grant}, 16'h0000);
    check("rst_skip_count", bus.skip_count, 16'h0000);
    check("rst_state", {14'h0, bus.state}, {14'h0, ST_IDLE});
    check("rst_ready", {14'h0, bus.req1_ready, bus.req0_ready}, 16'h0000);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.byte_en = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clock);
    #1 check_reset_vals();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       lb;
    logic       v1;
    bus.byte_en = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clock);

    cur_test = "idle_skip";
    do_reset();
    for (int i = 0; i < 63; i++) idle_slot(8'hBC);
    idle_slot(8'hBC);
    idle_slot(8'h1C);
    idle_slot(8'h1C);
    #2 check("skip_count_pre", bus.skip_count, 16'd0);
    idle_slot(8'h1C);
    idle_slot(8'hBC);
    quiet();
    check("skip_count", bus.skip_count, 16'd1);

    cur_test = "round_robin";
    do_reset();
    slot(1'b1, 8'h11, 1'b0, 1'b1, 8'hAA, 1'b0, 2'b01, 8'h11, 1'b0, 1'b1, 2'b01);
    slot(1'b1, 8'h22, 1'b0, 1'b1, 8'hAA, 1'b0, 2'b01, 8'h22, 1'b0, 1'b1, 2'b01);
    slot(1'b1, 8'h33, 1'b1, 1'b1, 8'hAA, 1'b0, 2'b01, 8'h33, 1'b0, 1'b1, 2'b00);
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'hAA, 1'b0, 2'b10, 8'hAA, 1'b0, 1'b1, 2'b10);
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'hBB, 1'b0, 2'b10, 8'hBB, 1'b0, 1'b1, 2'b10);
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'hCC, 1'b1, 2'b10, 8'hCC, 1'b0, 1'b1, 2'b00);
    slot(1'b1, 8'h44, 1'b0, 1'b1, 8'hDD, 1'b0, 2'b01, 8'h44, 1'b0, 1'b1, 2'b01);
    slot(1'b1, 8'h45, 1'b1, 1'b1, 8'hDD, 1'b0, 2'b01, 8'h45, 1'b0, 1'b1, 2'b00);
    slot(1'b1, 8'h55, 1'b0, 1'b1, 8'hDD, 1'b0, 2'b10, 8'hDD, 1'b0, 1'b1, 2'b10);
    slot(1'b1, 8'h55, 1'b0, 1'b1, 8'hDE, 1'b1, 2'b10, 8'hDE, 1'b0, 1'b1, 2'b00);
    idle_slot(8'hBC);
    quiet();

    cur_test = "underrun";
    do_reset();
    slot(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 8'h11, 1'b0, 1'b1, 2'b01);
    slot(1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 8'h22, 1'b0, 1'b1, 2'b01);
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b1, 2'b01, 8'hBC, 1'b1, 1'b0, 2'b01);
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b1, 2'b01, 8'hBC, 1'b1, 1'b0, 2'b01);
    slot(1'b1, 8'h33, 1'b1, 1'b1, 8'h99, 1'b1, 2'b01, 8'h33, 1'b0, 1'b1, 2'b00);
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b1, 2'b10, 8'h99, 1'b0, 1'b1, 2'b00);
    quiet();

    cur_test = "skip_in_frame";
    do_reset();
    for (int i = 0; i < 10; i++) idle_slot(8'hBC);
    for (int i = 0; i < 100; i++) begin
      b  = 8'(i + 1);
      lb = (i == 99);
      v1 = (i >= 40);
      slot(1'b1, b, lb, v1, 8'h55, 1'b1, 2'b01, b, 1'b0, 1'b1, lb ? 2'b00 : 2'b01);
    end
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, 2'b00, 8'hBC, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++)
      slot(1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, 2'b00, 8'h1C, 1'b1, 1'b0, 2'b00);
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, 2'b10, 8'h55, 1'b0, 1'b1, 2'b00);
    #2 check("skip_count_1", bus.skip_count, 16'd1);
    for (int i = 0; i < 60; i++) idle_slot(8'hBC);
    for (int i = 0; i < 3; i++) idle_slot(8'h1C);
    quiet();
    check("skip_count_2", bus.skip_count, 16'd2);

    cur_test = "sparse_byte_en";
    do_reset();
    slot(1'b1, 8'hA1, 1'b0, 1'b1, 8'hB1, 1'b0, 2'b01, 8'hA1, 1'b0, 1'b1, 2'b01);
    gap(7);
    slot(1'b1, 8'hA2, 1'b0, 1'b1, 8'hB1, 1'b0, 2'b01, 8'hA2, 1'b0, 1'b1, 2'b01);
    gap(7);
    slot(1'b1, 8'hA3, 1'b1, 1'b1, 8'hB1, 1'b0, 2'b01, 8'hA3, 1'b0, 1'b1, 2'b00);
    gap(7);
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b0, 2'b10, 8'hB1, 1'b0, 1'b1, 2'b10);
    gap(7);
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'hB2, 1'b1, 2'b10, 8'hB2, 1'b0, 1'b1, 2'b00);
    gap(7);
    quiet();

    cur_test = "reset_mid_frame";
    do_reset();
    slot(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 8'h11, 1'b0, 1'b1, 2'b01);
    slot(1'b1, 8'h12, 1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 8'h12, 1'b0, 1'b1, 2'b00);
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'hAA, 1'b0, 2'b10, 8'hAA, 1'b0, 1'b1, 2'b10);
    slot(1'b0, 8'h00, 1'b0, 1'b1, 8'hBB, 1'b0, 2'b10, 8'hBB, 1'b0, 1'b1, 2'b10);
    @(negedge clock);
    drive(1'b1, 8'h21, 1'b0, 1'b1, 8'hCC, 1'b0);
    bus.byte_en = 1'b1;
    reset = 1'b1;
    #1 check_reset_vals();
    @(negedge clock);
    bus.byte_en = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    slot(1'b1, 8'h21, 1'b0, 1'b1, 8'hCC, 1'b0, 2'b01, 8'h21, 1'b0, 1'b1, 2'b01);
    slot(1'b1, 8'h22, 1'b1, 1'b1, 8'hCC, 1'b0, 2'b01, 8'h22, 1'b0, 1'b1, 2'b00);
    quiet();

    repeat (2) @(negedge clock);
    check("exp_q_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
